// File: rtl/measure_pkg.sv
// Shared types and constants for the frame-length sweep controller.
package measure_pkg;

  // Width of one result word: {tx_count, rx_count}.
  localparam int unsigned RES_W = 64;

  // Frame lengths stepped through by the sweep. Entry 0 is the first trial.
  localparam logic [7:0][15:0] LEN_TABLE = {
    16'd1518, 16'd1518, 16'd1280, 16'd1024,
    16'd512,  16'd256,  16'd128,  16'd64
  };

  // Generator defaults applied at reset.
  localparam logic [15:0] RST_FRAME_LEN = 16'd64;
  localparam logic [31:0] RST_IFG       = 32'd12;

  typedef enum logic [3:0] {
    StIdle,
    StWaitLink,
    StSetup,
    StRun,
    StDrain,
    StRecord,
    StNext,
    StDone,
    StErr
  } sweep_state_e;

endpackage

// File: rtl/sat_cnt32.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Clear has priority over increment; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/measure_sweep_ctrl.sv
// Frame-length sweep sequencer for the port-0 generator: per length it runs a
// setup / run / drain trial, counts TX and RX frames and writes one result word.
module measure_sweep_ctrl
  import measure_pkg::*;
#(
  parameter int unsigned NUM_LEN     = 7,          // 1..8 entries of LEN_TABLE
  parameter int unsigned SETUP_CYC   = 1024,       // all cycle counts must be >= 1
  parameter int unsigned TRIAL_CYC   = 156250000,
  parameter int unsigned DRAIN_CYC   = 15625,
  parameter int unsigned LINK_TO_CYC = 156250000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             link_up,
  input  logic [31:0]      cfg_ifg,
  input  logic             tx_frame,
  input  logic             rx_frame,
  output logic             tx_enable,
  output logic [15:0]      frame_len,
  output logic [31:0]      inter_frame_gap,
  output logic             res_we,
  output logic [2:0]       res_addr,
  output logic [RES_W-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  sweep_state_e state_q, state_d;

  logic [31:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [31:0] ifg_q, ifg_d;
  logic        tx_enable_q, tx_enable_d;

  logic        active;     // any state that aborts/owns the generator
  logic        entering;   // state changes at the next edge
  logic        start_acc;  // start accepted this cycle
  logic        last_idx;
  logic        cnt_clear;
  logic        count_win;
  logic [31:0] tx_cnt, rx_cnt;

  // Cycles spent in each timed state; the timer counts down to 0 inclusive.
  function automatic logic [31:0] timer_load(sweep_state_e st);
    logic [31:0] val;
    val = '0;
    case (st)
      StWaitLink: val = 32'(LINK_TO_CYC - 1);
      StSetup:    val = 32'(SETUP_CYC - 1);
      StRun:      val = 32'(TRIAL_CYC - 1);
      StDrain:    val = 32'(DRAIN_CYC - 1);
      default:    val = '0;
    endcase
    return val;
  endfunction

  assign active   = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign last_idx = (idx_q == 3'(NUM_LEN - 1));

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything, link loss overrides timers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start && !abort) state_d = StWaitLink;
      end
      StWaitLink: begin
        if (link_up)               state_d = StSetup;
        else if (timer_q == '0)    state_d = StErr;
      end
      StSetup: begin
        if (!link_up)              state_d = StErr;
        else if (timer_q == '0)    state_d = StRun;
      end
      StRun: begin
        if (!link_up)              state_d = StErr;
        else if (timer_q == '0)    state_d = StDrain;
      end
      StDrain: begin
        if (!link_up)              state_d = StErr;
        else if (timer_q == '0)    state_d = StRecord;
      end
      StRecord: state_d = StNext;
      StNext:   state_d = last_idx ? StDone : StSetup;
      default:  state_d = StIdle;
    endcase
    if (abort && active) state_d = StIdle;
  end

  // Output decode from the current state.
  always_comb begin
    busy     = active;
    done     = (state_q == StDone);
    error    = (state_q == StErr);
    res_we   = (state_q == StRecord);
    res_addr = idx_q;
    res_data = res_we ? {tx_cnt, rx_cnt} : '0;
  end

  // Datapath next-state: shared timer, trial index and generator settings.
  always_comb begin
    entering  = (state_d != state_q);
    start_acc = !active && (state_d == StWaitLink);

    if (entering)              timer_d = timer_load(state_d);
    else if (timer_q != '0)    timer_d = timer_q - 32'd1;
    else                       timer_d = timer_q;

    idx_d = idx_q;
    if (start_acc)                                       idx_d = '0;
    else if ((state_q == StNext) && (state_d == StSetup)) idx_d = idx_q + 3'd1;

    frame_len_d = frame_len_q;
    if (entering && (state_d == StSetup)) frame_len_d = LEN_TABLE[idx_d];

    ifg_d       = start_acc ? cfg_ifg : ifg_q;
    tx_enable_d = (state_d == StRun);
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_q     <= '0;
      idx_q       <= '0;
      frame_len_q <= RST_FRAME_LEN;
      ifg_q       <= RST_IFG;
      tx_enable_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      frame_len_q <= frame_len_d;
      ifg_q       <= ifg_d;
      tx_enable_q <= tx_enable_d;
    end
  end

  assign tx_enable       = tx_enable_q;
  assign frame_len       = frame_len_q;
  assign inter_frame_gap = ifg_q;

  // Counters hold clear through SETUP so each trial starts from zero; frames are
  // counted while the generator runs and during drain so late RX is captured.
  assign cnt_clear = start_acc || (state_q == StSetup);
  assign count_win = (state_q == StRun) || (state_q == StDrain);

  sat_cnt32 #(
    .WIDTH (32)
  ) u_tx_cnt (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clear  (cnt_clear),
    .enable (count_win && tx_frame),
    .count  (tx_cnt)
  );

  sat_cnt32 #(
    .WIDTH (32)
  ) u_rx_cnt (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clear  (cnt_clear),
    .enable (count_win && rx_frame),
    .count  (rx_cnt)
  );

endmodule

// File: tb/tb_measure_sweep_ctrl.sv
// Directed bench for measure_sweep_ctrl with reduced trial lengths and a
// loopback generator model (TX pulse every 10 enabled cycles, RX 3 cycles later).
module tb_measure_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, link_up;
  logic [31:0] cfg_ifg;
  logic        tx_frame, rx_frame;
  logic        tx_enable;
  logic [15:0] frame_len;
  logic [31:0] inter_frame_gap;
  logic        res_we;
  logic [2:0]  res_addr;
  logic [63:0] res_data;
  logic        busy, done, error;

  logic        sat_clear, sat_en;
  logic [3:0]  sat_count;

  int          checks = 0;
  int          failures = 0;

  // Write log and generator model state.
  logic [2:0]  wr_addr [8];
  logic [15:0] wr_len  [8];
  logic [63:0] wr_data [8];
  int          wr_n = 0;
  bit          tx_en_seen = 0;
  bit          suppress_len128 = 0;
  int          en_cnt = 0;
  logic [2:0]  rx_pipe = '0;
  int          cyc;

  logic [15:0] exp_len [3];
  initial begin
    exp_len[0] = 16'd64;
    exp_len[1] = 16'd128;
    exp_len[2] = 16'd256;
  end

  always #5 clk = ~clk;

  measure_sweep_ctrl #(
    .NUM_LEN     (3),
    .SETUP_CYC   (4),
    .TRIAL_CYC   (100),
    .DRAIN_CYC   (10),
    .LINK_TO_CYC (50)
  ) dut (
    .sys_clk         (clk),
    .sys_rst_n       (rst_n),
    .start           (start),
    .abort           (abort),
    .link_up         (link_up),
    .cfg_ifg         (cfg_ifg),
    .tx_frame        (tx_frame),
    .rx_frame        (rx_frame),
    .tx_enable       (tx_enable),
    .frame_len       (frame_len),
    .inter_frame_gap (inter_frame_gap),
    .res_we          (res_we),
    .res_addr        (res_addr),
    .res_data        (res_data),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  // Narrow instance of the counter so saturation is reachable in a few cycles.
  sat_cnt32 #(
    .WIDTH (4)
  ) u_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (sat_clear),
    .enable (sat_en),
    .count  (sat_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor writes and act as the loopback generator, all on the falling edge.
  initial begin
    tx_frame = 1'b0;
    rx_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (res_we) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] = res_addr;
          wr_len[wr_n]  = frame_len;
          wr_data[wr_n] = res_data;
        end
        wr_n++;
      end
      if (tx_enable) begin
        tx_en_seen = 1;
        en_cnt++;
        tx_frame = ((en_cnt % 10) == 0);
      end else begin
        en_cnt   = 0;
        tx_frame = 1'b0;
      end
      rx_frame = rx_pipe[2] && !(suppress_len128 && (frame_len == 16'd128));
      rx_pipe  = {rx_pipe[1:0], tx_frame};
    end
  end

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(done || error) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 64'(done || error), 64'd1);
  endtask

  task automatic wait_run(input logic [15:0] len, input string tag);
    int n;
    n = 0;
    while (!(tx_enable && (frame_len == len)) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_run_reached"}, 64'(tx_enable && (frame_len == len)), 64'd1);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_start", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; link_up = 1'b1;
    cfg_ifg = 32'd20; sat_clear = 1'b0; sat_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_tx_enable", 64'(tx_enable), 64'd0);
    check("rst_frame_len", 64'(frame_len), 64'd64);
    check("rst_ifg", 64'(inter_frame_gap), 64'd12);
    check("rst_res_we", 64'(res_we), 64'd0);
    check("rst_res_addr", 64'(res_addr), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep: 3 trials, 10 TX and 10 RX each.
    wr_n = 0;
    do_start();
    wait_end("sweep1");
    check("sweep1_writes", 64'(wr_n), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sweep1_addr%0d", i), 64'(wr_addr[i]), 64'(i));
      check($sformatf("sweep1_len%0d", i), 64'(wr_len[i]), 64'(exp_len[i]));
      check($sformatf("sweep1_data%0d", i), wr_data[i], {32'd10, 32'd10});
    end
    check("sweep1_done", 64'(done), 64'd1);
    check("sweep1_busy", 64'(busy), 64'd0);
    check("sweep1_ifg", 64'(inter_frame_gap), 64'd20);

    // RX suppressed in trial 1; a mid-sweep start must be ignored.
    wr_n = 0;
    suppress_len128 = 1;
    do_start();
    check("sweep2_done_cleared", 64'(done), 64'd0);
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("sweep2");
    suppress_len128 = 0;
    check("sweep2_writes", 64'(wr_n), 64'd3);
    check("sweep2_data0", wr_data[0], {32'd10, 32'd10});
    check("sweep2_data1", wr_data[1], {32'd10, 32'd0});
    check("sweep2_data2", wr_data[2], {32'd10, 32'd10});

    // Link timeout: ERR 50 cycles after start, generator never enabled.
    link_up = 1'b0;
    tx_en_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!error && (cyc < 200)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("linkto_cycles", 64'(cyc), 64'd50);
    check("linkto_error", 64'(error), 64'd1);
    check("linkto_busy", 64'(busy), 64'd0);
    check("linkto_no_tx", 64'(tx_en_seen), 64'd0);
    @(negedge clk);
    link_up = 1'b1;
    do_start();
    check("restart_clears_error", 64'(error), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_wait_link_idle", 64'(busy), 64'd0);

    // start and abort together in IDLE: stays idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    check("start_abort_idle", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;

    // Abort at cycle 30 of RUN in trial 1.
    wr_n = 0;
    do_start();
    wait_run(16'd128, "abort");
    repeat (29) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx_enable", 64'(tx_enable), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_writes", 64'(wr_n), 64'd1);
    check("abort_addr0", 64'(wr_addr[0]), 64'd0);
    check("abort_stays_idle", 64'(busy), 64'd0);

    // Link drop mid-RUN of trial 0.
    wr_n = 0;
    do_start();
    wait_run(16'd64, "linkdrop");
    repeat (20) @(negedge clk);
    link_up = 1'b0;
    @(posedge clk);
    #1;
    check("linkdrop_tx_enable", 64'(tx_enable), 64'd0);
    check("linkdrop_error", 64'(error), 64'd1);
    @(negedge clk);
    link_up = 1'b1;
    repeat (150) @(negedge clk);
    check("linkdrop_writes", 64'(wr_n), 64'd0);
    check("linkdrop_error_sticky", 64'(error), 64'd1);

    // Saturating counter.
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0; sat_en = 1'b1;
    repeat (5) @(negedge clk);
    check("sat_count5", 64'(sat_count), 64'd5);
    repeat (15) @(negedge clk);
    check("sat_hold_max", 64'(sat_count), 64'hF);
    sat_en = 1'b0; sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;
    check("sat_clear", 64'(sat_count), 64'd0);

    // Asynchronous reset mid-RUN.
    do_start();
    wait_run(16'd64, "rstrun");
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstrun_tx_enable", 64'(tx_enable), 64'd0);
    check("rstrun_frame_len", 64'(frame_len), 64'd64);
    check("rstrun_ifg", 64'(inter_frame_gap), 64'd12);
    check("rstrun_busy", 64'(busy), 64'd0);
    check("rstrun_error", 64'(error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
